// File: rtl/cordic_rot_iter.sv
// cordic_rot_iter: iterative CORDIC rotation engine. A single shared shift/add
// datapath rotates one (x, y) vector by the binary angle z per transaction.
// The angle is 2^15 = pi and wraps modulo 2^16. The result is rounded and
// saturated to 12-bit re/im samples.
// Optional macro CORDIC_GAIN_COMP_EN adds a registered multiply by 1/K in Q15
// before the output stage. This removes the CORDIC gain and adds one cycle of
// latency.
module cordic_rot_iter #(
    parameter int ITER      = 14,
    parameter int GUARD     = 2,
    parameter int OUT_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rot_valid,
    output logic               ready_o,
    input  logic signed [15:0] ROT_x_i,
    input  logic signed [15:0] ROT_y_i,
    input  logic signed [15:0] ROT_z_i,
    output logic signed [11:0] x_re_out,
    output logic signed [11:0] x_im_out,
    output logic               valid_o
);

    localparam int W  = 16 + GUARD;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [CW-1:0]      LAST_I  = CW'(ITER - 1);
    localparam logic signed [15:0] QUAD    = 16'sd16384;
    localparam logic signed [W:0]  RND     = (W+1)'(1 << (OUT_SHIFT - 1));
    localparam logic signed [W:0]  SAT_MAX = (W+1)'(2047);
    localparam logic signed [W:0]  SAT_MIN = (W+1)'(-2048);

    // arctan(2^-i) in binary angle units
    localparam logic signed [15:0] ATAN_ROM [14] = '{
        16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297, 16'sd651, 16'sd326, 16'sd163,
        16'sd81,   16'sd41,   16'sd20,   16'sd10,   16'sd5,   16'sd3,   16'sd1
    };

`ifdef CORDIC_GAIN_COMP_EN
    // 1/K in Q15
    localparam logic signed [15:0] GAIN_Q15 = 16'sd19898;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_MUL,
        S_POST
    } state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] y_q, y_d;
    logic signed [15:0]  z_q, z_d;
    logic [CW-1:0]       i_q, i_d;
    logic signed [11:0]  re_q, re_d;
    logic signed [11:0]  im_q, im_d;

    logic                accept;
    logic                fold;
    logic signed [W-1:0] x_sh, y_sh;
    logic signed [15:0]  atan_i;
`ifdef CORDIC_GAIN_COMP_EN
    logic signed [W+15:0] x_prod, y_prod;
`endif

    // Only the first ITER arctan entries are reachable by the counter.
    logic signed [15:0] atan_tbl [ITER];
    genvar gi;
    generate
        for (gi = 0; gi < ITER; gi++) begin : g_atan
            assign atan_tbl[gi] = ATAN_ROM[gi];
        end
    endgenerate

    // Round half up at the output LSB, then clamp to the 12-bit signed range.
    function automatic logic signed [11:0] round_sat(input logic signed [W-1:0] v);
        logic signed [W:0] r;
        r = {v[W-1], v} + RND;
        r = r >>> OUT_SHIFT;
        if (r > SAT_MAX) begin
            return 12'sh7FF;
        end else if (r < SAT_MIN) begin
            return 12'sh800;
        end
        return r[11:0];
    endfunction

    // Next-state and datapath update for the fold / iterate / output sequence.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        valid_d = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        re_d    = re_q;
        im_d    = im_q;

        accept = rot_valid && ready_q;
        fold   = (z_q > QUAD) || (z_q < -QUAD);
        x_sh   = x_q >>> i_q;
        y_sh   = y_q >>> i_q;
        atan_i = atan_tbl[i_q];
`ifdef CORDIC_GAIN_COMP_EN
        x_prod = x_q * GAIN_Q15;
        y_prod = y_q * GAIN_Q15;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    x_d     = {{GUARD{ROT_x_i[15]}}, ROT_x_i};
                    y_d     = {{GUARD{ROT_y_i[15]}}, ROT_y_i};
                    z_d     = ROT_z_i;
                    ready_d = 1'b0;
                    state_d = S_PRE;
                end
            end

            S_PRE: begin
                // Angles beyond +/-pi/2 are rotated by pi first.
                // Negating the vector is exact; adding pi wraps in 16 bits.
                if (fold) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = z_q + 16'sh8000;
                end
                i_d     = '0;
                state_d = S_ITER;
            end

            S_ITER: begin
                if (!z_q[15]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end
                i_d = i_q + 1'b1;
                if (i_q == LAST_I) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = S_MUL;
`else
                    // The output cycle can already take the next sample.
                    ready_d = 1'b1;
                    state_d = S_POST;
`endif
                end
            end

`ifdef CORDIC_GAIN_COMP_EN
            S_MUL: begin
                // The scaled value is smaller than the input, so it fits in W bits.
                x_d     = x_prod[W+14:15];
                y_d     = y_prod[W+14:15];
                ready_d = 1'b1;
                state_d = S_POST;
            end
`endif

            S_POST: begin
                re_d    = round_sat(x_q);
                im_d    = round_sat(y_q);
                valid_d = 1'b1;
                // An accept here overlaps the output strobe with the next load.
                if (accept) begin
                    x_d     = {{GUARD{ROT_x_i[15]}}, ROT_x_i};
                    y_d     = {{GUARD{ROT_y_i[15]}}, ROT_y_i};
                    z_d     = ROT_z_i;
                    ready_d = 1'b0;
                    state_d = S_PRE;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers. Reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign x_re_out = re_q;
    assign x_im_out = im_q;

endmodule

// File: doc/cordic_rot_iter.md
Name: cordic_rot_iter

Overview:
- Iterative, single-datapath CORDIC rotation engine: polar/vector-plus-angle in, rotated Cartesian sample out.
- Area-optimised counterpart to the vectoring front end.
- Consumes the same (x, y, z) triplet format the vectoring stage emits and returns 12-bit re/im samples.
- One transaction in flight; rot_valid/ready_o handshake on input, single-cycle valid_o pulse on output.

Parameters:
- ITER, 14, number of micro-rotations (1..14); arctan ROM holds 14 entries.
- GUARD, 2, extra MSB guard bits on the internal x/y datapath (internal width 16+GUARD).
- OUT_SHIFT, 4, right shift from internal 16-bit scale to 12-bit output.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rot_valid  in  1  input triplet valid
- ready_o  out  1  block idle, can accept
- ROT_x_i  in  16  signed x (magnitude when fed from vectoring)
- ROT_y_i  in  16  signed y
- ROT_z_i  in  16  signed binary angle: 2^15 = pi, wraps mod 2^16
- x_re_out  out  12  signed rotated real part
- x_im_out  out  12  signed rotated imaginary part
- valid_o  out  1  one-cycle result strobe

Behaviour:
- Reset (sync, rst high at posedge): state=IDLE, ready_o=1, valid_o=0, x_re_out=0, x_im_out=0, iteration counter=0, datapath regs=0. Reset mid-operation aborts the transaction; no valid_o is ever produced for it.
- Accept: rot_valid && ready_o at posedge latches inputs, ready_o drops next cycle. rot_valid while ready_o=0 is ignored (no queueing).
- FSM:
  - IDLE -> PRE on accept.
  - PRE: quadrant fold. If z > 16384 or z < -16384 then x=-x, y=-y, z=z+32768 (wrapping 16-bit add); else pass through. z=-32768 folds to 0 with negated x, y.
  - PRE -> ITER, counter i=0.
  - ITER: each cycle d = (z >= 0) ? +1 : -1. Updates: x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan[i]. Arithmetic shifts, sign-extended to 16+GUARD bits. i increments; after i=ITER-1 -> POST.
  - POST: result x, y >>> OUT_SHIFT with round-half-up (add 2^(OUT_SHIFT-1) before shift). Saturate to [-2048, 2047]. Register to x_re_out/x_im_out, valid_o=1 for one cycle. -> IDLE with ready_o=1 in the same update.
- atan ROM (binary angle units): 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1.
- Latency: accept edge to valid_o high = ITER+2 clocks (16 at default). Back-to-back throughput = one sample per ITER+2 clocks; the next accept may occur on the same edge valid_o rises.
- x_re_out/x_im_out hold the last result until the next POST or reset.
- Output gain without compensation: K = 1.64676 (x_out ≈ K*|v|/16).

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined: POST multiplies x, y by 1/K in Q15 (19898) before shift/round/saturate. Multiply is registered, so latency becomes ITER+3 and output ≈ |v|/16.
- Undefined: no multiplier, latency ITER+2, output carries gain K.

Test Plan:
- Reset, then x=1000, y=0, z=0: valid_o at accept+16, x_re_out=103±1, x_im_out=0±1. With CORDIC_GAIN_COMP_EN: 62±1, 0±1 at accept+17.
- x=1000, y=0, z=16384 (pi/2): re=0±1, im=103±1. z=-32768 (pi, fold): re=-103±1, im=0±1. z=8192: re=73±1, im=73±1.
- Saturation: x=32767, y=32767, z=0: re=2047, im=2047, no wrap. x=-32768, y=0, z=0: re=-2048.
- Handshake: hold rot_valid high for 40 cycles with changing data. Exactly 3 accepts occur, at cycles 0, 16 and 32. Inputs during busy are ignored; each result matches its accepted sample; ready_o=0 exactly while busy.
- Reset mid-op: assert rst at accept+8 for one cycle. No valid_o follows, ready_o=1 and outputs=0 after the reset edge; a new accept then completes normally.
- Stream 255 random (x, y, z) samples with the same comparison model as the vectoring/rotation bench. Every output must be within ±2 LSB of a double-precision reference, and the valid_o count must equal 255.
